seven_seg_tick_counter: RTL
===========================

SEVEN_SEG_TICK_COUNTER -- requirements
Module: seven_seg_tick_counter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving CLK cycles per display digit slot (legal range 2..2^20).
REQ-002 CLK  input  1  system clock, all flops on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous and active-low.
REQ-004 CEIN  input  1  toggle tick from the clock divider; each transition, rising or falling, is one count event; asynchronous to the block.
REQ-005 CLR  input  1  synchronous clear of the count, active-high.
REQ-006 HOLD  input  1  freezes counting while high, active-high.
REQ-007 SEG  output  7  segment drive, active-low; SEG[0]=a ... SEG[6]=g.
REQ-008 AN  output  4  digit anode enables, active-low; AN[0]=ones digit ... AN[3]=thousands.
REQ-009 CARRY  output  1  one-cycle high pulse on wrap from 9999 to 0000.

Function
REQ-010 CEIN SHALL pass through a 2-flop synchronizer; an edge SHALL be detected when the second stage differs from a registered previous sample.
REQ-011 The first synchronized sample after reset release SHALL load the previous-sample register only; it SHALL NOT produce an edge, regardless of CEIN level.
REQ-012 Count SHALL be 4 BCD digits, 0000..9999; each detected edge with HOLD=0 and CLR=0 SHALL increment by 1 with decimal carry between digits.
REQ-013 Latency: a CEIN transition sampled at CLK edge k SHALL be reflected in the count after edge k+2.
REQ-014 At 9999 an increment SHALL give 0000 and set CARRY high for exactly that one cycle.
REQ-015 Edges detected while HOLD=1 SHALL be discarded, not queued; HOLD SHALL NOT affect display scanning.
REQ-016 CLR=1 SHALL set the count to 0000 on the next edge and SHALL take priority over a simultaneous count edge; no CARRY is produced by CLR.
REQ-017 A scan counter SHALL count 0..SCAN_DIV-1 and, on wrap, advance the digit index 0->1->2->3->0.
REQ-018 Exactly one AN bit SHALL be low at any time after reset, namely AN[index]; SEG SHALL show the selected digit, both registered in the same cycle.
REQ-019 Segment codes, active-low as SEG[6:0]: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
REQ-020 Count changes SHALL appear on SEG no later than the next slot for that digit; no intermediate codes other than valid digits or blank SHALL be driven.

Reset
REQ-021 RST_N low SHALL immediately force: count 0000, synchronizer and previous-sample flops 0, first-sample flag set, scan counter 0, index 0, SEG=1111111, AN=1111, CARRY=0.
REQ-022 Reset asserted mid-scan or mid-count SHALL abandon all state; the first scan slot after release SHALL be digit 0 with full SCAN_DIV length.

Configuration
REQ-023 Macro SEVSEG_LEADING_ZERO_BLANK_EN: when defined, leading zero digits of digits 3..1 SHALL drive SEG=1111111 (AN still scans), digit 0 always shown; when undefined, all four digits SHALL always show their value.

Verification (SCAN_DIV=4)
REQ-024 Reset with CEIN=1, release, hold CEIN=1 for 20 cycles -> count stays 0000, CARRY never high.
REQ-025 Toggle CEIN 12 times, 10 cycles apart -> count 0012; with digit 1 selected SEG=1111001 and AN=1101.
REQ-026 Preload to 9998 via 9998 edges, 2 more edges -> count 0000, CARRY high exactly one cycle on the second edge's update.
REQ-027 CLR=1 in the same cycle a detected edge updates, count 0057 -> count 0000 next cycle, no CARRY.
REQ-028 HOLD=1 during 5 edges, then HOLD=0 -> count unchanged, no late increment; AN sequence 1110,1101,1011,0111 each 4 cycles continues throughout.
REQ-029 With SEVSEG_LEADING_ZERO_BLANK_EN defined, count 0007 -> digits 3..1 SEG=1111111, digit 0 SEG=1111000; undefined -> digits 3..1 SEG=1000000.

Source files
------------

// File: rtl/seven_seg_tick_counter.sv
// Purpose: 4-digit BCD counter of CEIN toggle events, multiplexed onto a 4-digit active-low 7-segment display.
// Latency: a CEIN transition sampled at CLK edge k updates the count at edge k+2; SEG/AN follow the count one cycle later.
// Backpressure: none; edges seen while HOLD=1 are dropped, and scanning is free-running.
// Option: define SEVSEG_LEADING_ZERO_BLANK_EN to blank leading zeros on digits 3..1.
module seven_seg_tick_counter #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CEIN,
  input  logic       CLR,
  input  logic       HOLD,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       CARRY
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  // CEIN synchronizer and edge-detect state
  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       first_q;
  logic [1:0] fill_q;
  logic       tick;

  // count state
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        carry_q;
  logic        carry_d;
  logic        cy;

  // scan and display state
  logic [SW-1:0] scan_q;
  logic [SW-1:0] scan_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [6:0]    seg_q;
  logic [6:0]    seg_d;
  logic [3:0]    an_q;
  logic [3:0]    an_d;
  logic [3:0]    dig;
  logic          blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Synchronize CEIN. fill_q tracks when sync2_q first holds a real sample;
  // that sample only primes prev_q, so a high CEIN at release is not an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      first_q <= 1'b1;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= CEIN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1]) begin
        first_q <= 1'b0;
      end
    end
  end

  assign tick = !first_q && (sync2_q != prev_q);

  // BCD increment with ripple decimal carry; CLR wins over a same-cycle tick
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    cy      = 1'b1;
    if (CLR) begin
      cnt_d = '0;
    end else if (tick && !HOLD) begin
      for (int i = 0; i < 4; i++) begin
        if (cy) begin
          if (cnt_q[4*i +: 4] == 4'd9) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            cy              = 1'b0;
          end
        end
      end
      carry_d = cy;
    end
  end

  // Count register and the one-cycle wrap pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Scan slot timer and digit index advance
  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Digit selection, optional leading-zero blanking, and decode
  always_comb begin
    dig   = cnt_q[{idx_q, 2'b00} +: 4];
    blank = 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    blank = (cnt_q[15:12] == 4'd0);
      2'd2:    blank = (cnt_q[15:8] == 8'd0);
      2'd1:    blank = (cnt_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    seg_d = blank ? 7'b1111111 : seg_code(dig);
    an_d  = ~(4'b0001 << idx_q);
  end

  // Scan counter, index, and the registered display outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      seg_q  <= 7'b1111111;
      an_q   <= 4'b1111;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign CARRY = carry_q;

endmodule
